// File: rtl/seq_ctrl_pkg.sv
// Shared types and default sizes for the serial pattern detection controller.
package seq_ctrl_pkg;

   localparam int PAT_W_DEF = 4;
   localparam int CNT_W_DEF = 4;
   localparam int WIN_W_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ARM    = 2'd1,
      ST_HUNT   = 2'd2,
      ST_REPORT = 2'd3
   } state_t;

endpackage

// File: rtl/seq_pattern_match.sv
// Serial pattern matcher: shift register, fill count and comparator.
// o_match is combinational and reflects the bit being shifted in this cycle.
module seq_pattern_match #(
   parameter int PAT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clear,
   input  logic             i_en,
   input  logic             i_bit,
   input  logic [PAT_W-1:0] i_pattern,
   input  logic             i_overlap,
   output logic             o_match
);

   localparam int FILL_W = $clog2(PAT_W + 1);

   logic [PAT_W-1:0]  r_shift;
   logic [FILL_W-1:0] r_fill;
   logic [PAT_W-1:0]  w_shift_upd;
   logic [FILL_W-1:0] w_fill_inc;

   // Next shift contents and saturating fill, compared against the pattern
   always_comb begin
      w_shift_upd = {r_shift[PAT_W-2:0], i_bit};
      w_fill_inc  = (r_fill == FILL_W'(PAT_W)) ? r_fill : r_fill + 1'b1;
      o_match     = i_en && (w_fill_inc == FILL_W'(PAT_W)) && (w_shift_upd == i_pattern);
   end

   // Shift only on enabled cycles; a non-overlapping match restarts the fill
   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_shift <= '0;
         r_fill  <= '0;
      end else if (i_en) begin
         r_shift <= w_shift_upd;
         r_fill  <= (o_match && !i_overlap) ? '0 : w_fill_inc;
      end
   end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Session controller for serial pattern detection: arms on start, hunts for
// matches within an optional cycle window, reports done/timeout until ack.
// Optional feature macro: SEQ_CTRL_MATCH_LOG_EN adds first_match_pos/valid.
module seq_detect_ctrl
   import seq_ctrl_pkg::*;
#(
   parameter int PAT_W = PAT_W_DEF,
   parameter int CNT_W = CNT_W_DEF,
   parameter int WIN_W = WIN_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic             ack,
   input  logic [PAT_W-1:0] pattern,
   input  logic             overlap,
   input  logic [CNT_W-1:0] target,
   input  logic [WIN_W-1:0] window,
   input  logic             in,
   input  logic             in_valid,
   output logic             detected,
   output logic             busy,
   output logic             done,
   output logic             timeout,
   output logic [1:0]       dbg_state,
`ifdef SEQ_CTRL_MATCH_LOG_EN
   output logic [WIN_W-1:0] first_match_pos,
   output logic             first_match_valid,
`endif
   output logic [CNT_W-1:0] match_count
);

   state_t           r_state, w_state_next;
   logic             r_done, w_done_next;
   logic             r_timeout, w_timeout_next;
   logic             r_detected, w_detected_next;
   logic [CNT_W-1:0] r_cnt, w_cnt_next, w_cnt_inc;
   logic [WIN_W-1:0] r_win, w_win_next, w_win_inc;
   logic [PAT_W-1:0] r_pattern;
   logic             r_overlap;
   logic [CNT_W-1:0] r_target;
   logic [WIN_W-1:0] r_window;
   logic             w_arm, w_shift_en, w_match;

   // Abort outranks everything, so it also suppresses arming and shifting
   assign w_arm      = (r_state == ST_ARM) && !abort;
   assign w_shift_en = (r_state == ST_HUNT) && !abort && in_valid;
   assign w_cnt_inc  = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
   assign w_win_inc  = r_win + 1'b1;

   seq_pattern_match #(.PAT_W(PAT_W)) u_match (
      .clk       (clk),
      .rst       (rst),
      .i_clear   (w_arm),
      .i_en      (w_shift_en),
      .i_bit     (in),
      .i_pattern (r_pattern),
      .i_overlap (r_overlap),
      .o_match   (w_match)
   );

   // Session configuration is captured once in ARM; target 0 means 1
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pattern <= '0;
         r_overlap <= 1'b0;
         r_target  <= CNT_W'(1);
         r_window  <= '0;
      end else if (w_arm) begin
         r_pattern <= pattern;
         r_overlap <= overlap;
         r_target  <= (target == '0) ? CNT_W'(1) : target;
         r_window  <= window;
      end
   end

   // Next state, counters and flags; success beats window expiry
   always_comb begin
      w_state_next    = r_state;
      w_done_next     = r_done;
      w_timeout_next  = r_timeout;
      w_detected_next = 1'b0;
      w_cnt_next      = r_cnt;
      w_win_next      = r_win;
      case (r_state)
         ST_IDLE: begin
            if (start) w_state_next = ST_ARM;
         end
         ST_ARM: begin
            if (abort) begin
               w_state_next   = ST_IDLE;
               w_done_next    = 1'b0;
               w_timeout_next = 1'b0;
            end else begin
               w_cnt_next   = '0;
               w_win_next   = '0;
               w_state_next = ST_HUNT;
            end
         end
         ST_HUNT: begin
            if (abort) begin
               w_state_next   = ST_IDLE;
               w_done_next    = 1'b0;
               w_timeout_next = 1'b0;
            end else begin
               w_win_next = w_win_inc;
               if (w_match) begin
                  w_detected_next = 1'b1;
                  w_cnt_next      = w_cnt_inc;
               end
               if (w_match && (w_cnt_inc == r_target)) begin
                  w_done_next  = 1'b1;
                  w_state_next = ST_REPORT;
               end else if ((r_window != '0) && (w_win_inc == r_window)) begin
                  w_timeout_next = 1'b1;
                  w_state_next   = ST_REPORT;
               end
            end
         end
         ST_REPORT: begin
            if (abort || ack) begin
               w_state_next   = ST_IDLE;
               w_done_next    = 1'b0;
               w_timeout_next = 1'b0;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_done     <= 1'b0;
         r_timeout  <= 1'b0;
         r_detected <= 1'b0;
         r_cnt      <= '0;
         r_win      <= '0;
      end else begin
         r_state    <= w_state_next;
         r_done     <= w_done_next;
         r_timeout  <= w_timeout_next;
         r_detected <= w_detected_next;
         r_cnt      <= w_cnt_next;
         r_win      <= w_win_next;
      end
   end

`ifdef SEQ_CTRL_MATCH_LOG_EN
   logic [WIN_W-1:0] r_first_pos;
   logic             r_first_valid;

   // Record the window count of the first match in each session
   always_ff @(posedge clk) begin
      if (rst || w_arm) begin
         r_first_pos   <= '0;
         r_first_valid <= 1'b0;
      end else if (w_detected_next && !r_first_valid) begin
         r_first_pos   <= r_win;
         r_first_valid <= 1'b1;
      end
   end

   assign first_match_pos   = r_first_pos;
   assign first_match_valid = r_first_valid;
`endif

   assign detected    = r_detected;
   assign busy        = (r_state == ST_ARM) || (r_state == ST_HUNT);
   assign done        = r_done;
   assign timeout     = r_timeout;
   assign match_count = r_cnt;
   assign dbg_state   = r_state;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Bench for seq_detect_ctrl: directed scenarios followed by random traffic,
// all checked cycle by cycle against a behavioural session model.
module tb_seq_detect_ctrl;

   localparam int PAT_W = 4;
   localparam int CNT_W = 4;
   localparam int WIN_W = 8;

   logic             clk = 1'b0;
   logic             rst, start, abort, ack, in_bit, in_valid, overlap;
   logic [PAT_W-1:0] pattern;
   logic [CNT_W-1:0] target;
   logic [WIN_W-1:0] window;
   logic             detected, busy, done, timeout;
   logic [1:0]       dbg_state;
   logic [CNT_W-1:0] match_count;

   int n_checks = 0;
   int n_errors = 0;

   // model: phase 0 idle, 1 arming, 2 hunting, 3 reporting
   int               m_phase, m_tgt, m_win, m_hunt, m_cnt;
   logic [PAT_W-1:0] m_pat;
   bit               m_ovl, m_done, m_to, m_det;
   bit               m_q[$];
   logic [CNT_W-1:0] exp_q[$];

   seq_detect_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .ack(ack),
      .pattern(pattern), .overlap(overlap), .target(target), .window(window),
      .in(in_bit), .in_valid(in_valid), .detected(detected), .busy(busy),
      .done(done), .timeout(timeout), .dbg_state(dbg_state),
      .match_count(match_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [PAT_W-1:0] q_value();
      logic [PAT_W-1:0] v = '0;
      foreach (m_q[i]) v = {v[PAT_W-2:0], m_q[i]};
      return v;
   endfunction

   task automatic model_reset();
      m_phase = 0; m_det = 0; m_done = 0; m_to = 0; m_cnt = 0; m_hunt = 0;
      m_q.delete();
   endtask

   task automatic model_step(input bit s, input bit a, input bit k, input bit b, input bit v);
      bit hit;
      m_det = 0;
      case (m_phase)
         0: if (s) m_phase = 1;
         1: begin
            if (a) begin
               m_phase = 0; m_done = 0; m_to = 0;
            end else begin
               m_pat = pattern; m_ovl = overlap;
               m_tgt = (target == 0) ? 1 : int'(target);
               m_win = int'(window);
               m_cnt = 0; m_hunt = 0; m_q.delete();
               m_phase = 2;
            end
         end
         2: begin
            if (a) begin
               m_phase = 0; m_done = 0; m_to = 0;
            end else begin
               m_hunt++;
               hit = 0;
               if (v) begin
                  m_q.push_back(b);
                  if (m_q.size() > PAT_W) void'(m_q.pop_front());
                  if (m_q.size() == PAT_W && q_value() == m_pat) begin
                     hit = 1; m_det = 1;
                     if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
                     if (!m_ovl) m_q.delete();
                  end
               end
               if (hit && m_cnt == m_tgt) begin
                  m_done = 1; m_phase = 3;
               end else if (m_win != 0 && m_hunt == m_win) begin
                  m_to = 1; m_phase = 3;
               end
            end
         end
         default: if (a || k) begin
            m_phase = 0; m_done = 0; m_to = 0;
         end
      endcase
   endtask

   task automatic check_outputs();
      if (m_det) exp_q.push_back(CNT_W'(m_cnt));
      check("detected", detected, m_det);
      check("busy", busy, (m_phase == 1 || m_phase == 2));
      check("done", done, m_done);
      check("timeout", timeout, m_to);
      check("match_count", match_count, m_cnt);
      if (detected) begin
         if (exp_q.size() == 0) check("det_unexpected", detected, 0);
         else check("det_count", match_count, exp_q.pop_front());
      end
   endtask

   // one clock: drive, advance model, sample 1ns after the edge
   task automatic cycle(input logic s, input logic a, input logic k, input logic b,
                        input logic v, input logic r = 1'b0);
      start = s; abort = a; ack = k; in_bit = b; in_valid = v; rst = r;
      if (r) model_reset();
      else model_step(s, a, k, b, v);
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
   endtask

   task automatic begin_session(input logic [PAT_W-1:0] p, input logic o,
                                input logic [CNT_W-1:0] t, input logic [WIN_W-1:0] w);
      pattern = p; overlap = o; target = t; window = w;
      cycle(1, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);
   endtask

   task automatic send_bits(input logic [31:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--) cycle(0, 0, 0, bits[i], 1);
   endtask

   initial begin
      logic [3:0] alt;
      rst = 1'b1; start = 0; abort = 0; ack = 0; in_bit = 0; in_valid = 0;
      pattern = '0; overlap = 0; target = '0; window = '0;
      model_reset();

      // reset
      cycle(0, 0, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 0, 1);
      check("rst_busy", busy, 0);
      check("rst_count", match_count, 0);
      idle(2);

      // overlapping matches reach target 2
      begin_session(4'b1011, 1, 2, 0);
      send_bits(4'b1011, 4);
      check("s1_det1", detected, 1);
      send_bits(3'b011, 3);
      check("s1_det2", detected, 1);
      check("s1_done", done, 1);
      check("s1_cnt", match_count, 2);
      cycle(0, 0, 1, 0, 0);
      check("s1_ack", done, 0);

      // non-overlapping: only one match
      begin_session(4'b1011, 0, 2, 0);
      send_bits(4'b1011, 4);
      check("s2_det1", detected, 1);
      send_bits(3'b011, 3);
      check("s2_det2", detected, 0);
      check("s2_busy", busy, 1);
      check("s2_done", done, 0);
      check("s2_cnt", match_count, 1);
      cycle(0, 1, 0, 0, 0);

      // window expiry
      begin_session(4'b1011, 0, 1, 5);
      send_bits(0, 4);
      check("s3_pre_to", timeout, 0);
      send_bits(0, 1);
      check("s3_to", timeout, 1);
      check("s3_cnt", match_count, 0);
      idle(3);
      check("s3_hold", timeout, 1);
      cycle(0, 0, 1, 0, 0);
      check("s3_ack", timeout, 0);

      // match and expiry on the same cycle: done wins
      begin_session(4'b1011, 0, 1, 7);
      send_bits(7'b0001011, 7);
      check("s4_done", done, 1);
      check("s4_to", timeout, 0);
      cycle(0, 0, 1, 0, 0);

      // abort mid-hunt, then start ignored during REPORT and on ack
      begin_session(4'b1011, 0, 1, 0);
      send_bits(3'b101, 3);
      cycle(0, 1, 0, 0, 0);
      check("s5_busy", busy, 0);
      check("s5_done", done, 0);
      begin_session(4'b1011, 0, 1, 2);
      send_bits(2'b00, 2);
      for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0);
      check("s5_rep_busy", busy, 0);
      check("s5_rep_to", timeout, 1);
      cycle(1, 0, 1, 0, 0);
      check("s5_ack_to", timeout, 0);
      idle(1);
      check("s5_no_arm", busy, 0);

      // reset mid-hunt, then gapped input still matches
      begin_session(4'b1011, 1, 3, 0);
      send_bits(5'b10111, 5);
      check("s6_cnt1", match_count, 1);
      cycle(0, 0, 0, 0, 0, 1);
      check("s6_det", detected, 0);
      check("s6_busy", busy, 0);
      check("s6_done", done, 0);
      check("s6_cnt", match_count, 0);
      begin_session(4'b1011, 0, 1, 0);
      alt = 4'b1011;
      for (int i = 3; i >= 0; i--) begin
         cycle(0, 0, 0, alt[i], 1);
         if (i == 0) begin
            check("s6_gap_det", detected, 1);
            check("s6_gap_done", done, 1);
         end
         cycle(0, 0, 0, 1'($urandom_range(0, 1)), 0);
      end
      cycle(0, 0, 1, 0, 0);

      // random traffic
      for (int n = 0; n < 4000; n++) begin
         logic s, a, k, b, v, r;
         if ($urandom_range(0, 7) == 0) begin
            pattern = PAT_W'($urandom_range(0, 15));
            overlap = 1'($urandom_range(0, 1));
            target  = CNT_W'($urandom_range(0, 3));
            window  = ($urandom_range(0, 2) == 0) ? '0 : WIN_W'($urandom_range(3, 40));
         end
         s = ($urandom_range(0, 3) == 0);
         a = ($urandom_range(0, 59) == 0);
         k = ($urandom_range(0, 5) == 0);
         b = 1'($urandom_range(0, 1));
         v = ($urandom_range(0, 9) < 7);
         r = ($urandom_range(0, 299) == 0);
         cycle(s, a, k, b, v, r);
      end

      check("exp_q_left", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
